// File: rtl/aes_ctr_pkg.sv
// Shared types and defaults for the AES-CTR scheduler and its keystream FIFO.
package aes_ctr_pkg;

    localparam int CTR_WIDTH_DEFAULT = 32;
    localparam int KS_DEPTH_DEFAULT  = 8;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sched_state_e;

endpackage

// File: rtl/aes_ctr_scheduler_ks_fifo.sv
// Synchronous keystream FIFO with occupancy count and single-cycle flush.
module ks_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (cnt_q != FULL_CNT);
    assign pop_ok  = pop && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/aes_ctr_scheduler.sv
// CTR-mode sequencer for a pipelined AES-256 core: counter issue under credit, keystream XOR.
// Optional macro CTR_WRAP_ERR_EN: stop issuing and flag ctr_err when the counter would wrap.
module aes_ctr_scheduler
    import aes_ctr_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int CTR_WIDTH  = CTR_WIDTH_DEFAULT,
    parameter int KS_DEPTH   = KS_DEPTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] iv,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] core_tdata,
    output logic                  core_tvalid,
    input  logic                  core_tready,
    input  logic [DATA_WIDTH-1:0] ks_tdata,
    input  logic                  ks_tvalid,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  ctr_err
);

    if (DATA_WIDTH != 128) begin : g_bad_width
        $error("aes_ctr_scheduler: DATA_WIDTH must be 128");
    end
    if ((KS_DEPTH < 2) || ((KS_DEPTH & (KS_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("aes_ctr_scheduler: KS_DEPTH must be a power of 2 and >= 2");
    end

    localparam int CNT_W = $clog2(KS_DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(KS_DEPTH);

    function automatic block_t next_ctr(input block_t c);
        block_t n;
        n = c;
        n[CTR_WIDTH-1:0] = c[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
        return n;
    endfunction

    sched_state_e     state_q;
    sched_state_e     state_next;
    block_t           ctr_q;
    logic             core_vld_q;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_next;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_next;
    logic [CNT_W:0]   reserved_next;
    logic             fifo_empty;
    logic             fifo_flush;
    block_t           ks_head;
    logic             core_hs;
    logic             ks_push;
    logic             s_hs;
    logic             m_free;
    logic             issue_next;
    logic             err_next;
    logic             done_q;
    block_t           ct_p1;
    logic             vld_p1;
    logic             last_p1;

    assign m_free        = !vld_p1 || m_axis_tready;
    assign s_axis_tready = (state_q == RUN) && !fifo_empty && m_free;
    assign s_hs          = s_axis_tready && s_axis_tvalid;
    assign core_hs       = core_vld_q && core_tready;
    assign ks_push       = ks_tvalid && (inflight_q != '0);
    assign fifo_flush    = (state_q == FLUSH) && (state_next == IDLE);

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (s_hs && s_axis_tlast) state_next = FLUSH;
            FLUSH:   if ((inflight_q == '0) && !core_vld_q && m_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Credit accounting looks one cycle ahead so a new request is raised only
    // when the block it carries is already guaranteed a FIFO slot.
    always_comb begin
        inflight_next = inflight_q;
        if (core_hs && !ks_push)      inflight_next = inflight_q + CNT_W'(1);
        else if (!core_hs && ks_push) inflight_next = inflight_q - CNT_W'(1);
        fifo_next = fifo_count;
        if (ks_push && !s_hs)         fifo_next = fifo_count + CNT_W'(1);
        else if (!ks_push && s_hs)    fifo_next = fifo_count - CNT_W'(1);
        reserved_next = {1'b0, inflight_next} + {1'b0, fifo_next};
        issue_next    = (state_next == RUN) && !err_next && (reserved_next < CREDIT_MAX);
    end

`ifdef CTR_WRAP_ERR_EN
    logic err_q;
    logic wrap_hit;

    assign wrap_hit = core_hs && (&ctr_q[CTR_WIDTH-1:0]);
    assign err_next = err_q || wrap_hit;
    assign ctr_err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_next;
    end
`else
    assign err_next = 1'b0;
    assign ctr_err  = 1'b0;
`endif

    // Counter / issue stage: request is held with stable data until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ctr_q      <= '0;
            core_vld_q <= 1'b0;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_next;
            inflight_q <= inflight_next;
            done_q     <= fifo_flush;
            if ((state_q == IDLE) && start) ctr_q <= iv;
            else if (core_hs)               ctr_q <= next_ctr(ctr_q);
            if (!core_vld_q || core_tready) core_vld_q <= issue_next;
        end
    end

    ks_fifo #(
        .DEPTH (KS_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ks_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ks_push),
        .pop   (s_hs),
        .flush (fifo_flush),
        .din   (ks_tdata),
        .dout  (ks_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // p1: ciphertext output register, one cycle after the plaintext handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ct_p1   <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (s_hs) begin
            ct_p1   <= s_axis_tdata ^ ks_head;
            vld_p1  <= 1'b1;
            last_p1 <= s_axis_tlast;
        end else if (m_axis_tready) begin
            vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && ks_tvalid) begin
            assert (inflight_q != '0)
                else $error("aes_ctr_scheduler: keystream returned with nothing in flight");
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign core_tdata    = ctr_q;
    assign core_tvalid   = core_vld_q;
    assign m_axis_tdata  = ct_p1;
    assign m_axis_tvalid = vld_p1;
    assign m_axis_tlast  = last_p1;

endmodule

// File: tb/tb_aes_ctr_scheduler.sv
// Scoreboard bench for aes_ctr_scheduler with a fixed-latency core model and random handshakes.
module tb_aes_ctr_scheduler;

    localparam int KS_DEPTH = 8;
    localparam int LAT      = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] iv;
    logic         busy, done;
    logic [127:0] core_tdata;
    logic         core_tvalid, core_tready;
    logic [127:0] ks_tdata;
    logic         ks_tvalid;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic         ctr_err;

    aes_ctr_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .iv(iv), .busy(busy), .done(done),
        .core_tdata(core_tdata), .core_tvalid(core_tvalid), .core_tready(core_tready),
        .ks_tdata(ks_tdata), .ks_tvalid(ks_tvalid),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .ctr_err(ctr_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [127:0] data; logic last; } exp_t;
    typedef struct { int unsigned due; logic [127:0] data; } ks_ent_t;

    exp_t         exp_q[$];
    ks_ent_t      pipe_q[$];
    logic [127:0] issued_q[$];
    int           checks = 0;
    int           failures = 0;
    int           issued_cnt = 0;
    int           consumed_cnt = 0;
    int           sink_pct = 100;

    // Stand-in for the AES core: any fixed keyed permutation-like mix will do.
    function automatic logic [127:0] ks_fn(input logic [127:0] c);
        logic [127:0] x;
        x = c ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        for (int r = 0; r < 3; r++)
            x = {x[100:0], x[127:101]} ^ (x * 128'h9e3779b9_7f4a7c15_f39cc060_5cedc835);
        return x;
    endfunction

    function automatic logic [127:0] ctr_at(input logic [127:0] base, input int k);
        return {base[127:32], base[31:0] + 32'(k)};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Core model: accepts on handshake, returns ks_fn(block) LAT cycles later.
    initial begin
        int unsigned  cyc = 0;
        bit           prev_stall = 0;
        logic [127:0] prev_data = '0;
        core_tready = 1'b0;
        ks_tvalid   = 1'b0;
        ks_tdata    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                pipe_q.delete();
                prev_stall   = 0;
                issued_cnt   = 0;
                consumed_cnt = 0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!(core_tvalid && core_tdata == prev_data)) begin
                        failures++;
                        $display("FAIL core_tdata_stable: got vld=%0b %h want vld=1 %h",
                                 core_tvalid, core_tdata, prev_data);
                    end
                end
                if (core_tvalid && core_tready) begin
                    pipe_q.push_back('{due: cyc + LAT - 1, data: ks_fn(core_tdata)});
                    issued_q.push_back(core_tdata);
                    issued_cnt++;
                end
                if (s_axis_tvalid && s_axis_tready) consumed_cnt++;
                prev_stall = core_tvalid && !core_tready;
                prev_data  = core_tdata;
                if (busy) begin
                    checks++;
                    if (issued_cnt - consumed_cnt > KS_DEPTH) begin
                        failures++;
                        $display("FAIL credit: got %0d outstanding want <= %0d",
                                 issued_cnt - consumed_cnt, KS_DEPTH);
                    end
                end
            end
            @(posedge clk);
            #1;
            core_tready = ($urandom_range(99) < 70);
            if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
                ks_tvalid = 1'b1;
                ks_tdata  = pipe_q[0].data;
                void'(pipe_q.pop_front());
            end else begin
                ks_tvalid = 1'b0;
            end
        end
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = ($urandom_range(99) < sink_pct);
        end
    end

    // Monitor: pops expected ciphertext on every output handshake.
    initial begin
        bit   prev_done = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_axis_tvalid && m_axis_tready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL ct_unexpected: got %h want none", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
                            failures++;
                            $display("FAIL ct: got %h last=%0b want %h last=%0b",
                                     m_axis_tdata, m_axis_tlast, e.data, e.last);
                        end
                    end
                end
                if (done) begin
                    checks++;
                    if (prev_done) begin
                        failures++;
                        $display("FAIL done_pulse: got 2+ cycles want 1");
                    end
                end
            end
            prev_done = done && !rst;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [127:0] v);
        @(posedge clk);
        #1;
        start = 1'b1;
        iv    = v;
        issued_q.delete();
        issued_cnt   = 0;
        consumed_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic offer_block(input logic [127:0] pt, input logic last, input int pct,
                               input bit pulse, input int bound, output bit ok);
        ok = 0;
        for (int c = 0; c < bound; c++) begin
            @(posedge clk);
            #1;
            start = pulse && (c == 0);
            if (pulse && c == 0) iv = rand128();
            if (c == 0 || !s_axis_tvalid) begin
                s_axis_tvalid = ($urandom_range(99) < pct);
                s_axis_tdata  = pt;
                s_axis_tlast  = last;
            end
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_done"}, 128'(seen), 128'(1));
        chk({name, "_drained"}, 128'(exp_q.size()), 128'(0));
        chk({name, "_idle"}, 128'(busy), 128'(0));
    endtask

    task automatic send_msg(input string name, input logic [127:0] v, input int n,
                            input int s_pct, input int start_at);
        logic [127:0] pt;
        bit           ok;
        do_start(v);
        for (int k = 0; k < n; k++) begin
            pt = rand128();
            exp_q.push_back('{data: pt ^ ks_fn(ctr_at(v, k)), last: (k == n - 1)});
            offer_block(pt, k == n - 1, s_pct, k == start_at, 3000, ok);
            if (!ok) begin
                chk({name, "_accept"}, 128'(ok), 128'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        start = 1'b0;
        wait_done(name);
    endtask

    task automatic check_issued(input string name, input logic [127:0] v, input int n);
        chk({name, "_issue_cnt"}, 128'(issued_q.size() >= n), 128'(1));
        if (issued_q.size() >= n)
            for (int i = 0; i < n; i++) chk({name, "_ctr"}, issued_q[i], ctr_at(v, i));
    endtask

    task automatic check_idle(input string name);
        chk({name, "_ctl"}, 128'({busy, done, core_tvalid, m_axis_tvalid, m_axis_tlast,
                                  ctr_err, s_axis_tready}), 128'(0));
        chk({name, "_data"}, core_tdata | m_axis_tdata, 128'(0));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] pt;
        bit           ok;
        bit           reached;
        rst = 1'b1; start = 1'b0; iv = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        sink_pct = 100;
        v = {$urandom, $urandom, $urandom, 32'h0};
        send_msg("t1", v, 4, 100, -1);
        check_issued("t1", v, 4);

        sink_pct = 40;
        v = rand128();
        send_msg("t2", v, 64, 30, -1);

        sink_pct = 70;
        v = {$urandom, $urandom, $urandom, 32'hFFFF_FFFE};
`ifdef CTR_WRAP_ERR_EN
        do_start(v);
        for (int k = 0; k < 2; k++) begin
            pt = rand128();
            exp_q.push_back('{data: pt ^ ks_fn(ctr_at(v, k)), last: 1'b0});
            offer_block(pt, 1'b0, 100, 1'b0, 500, ok);
            chk("t3_accept", 128'(ok), 128'(1));
        end
        for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(negedge clk);
        chk("t3_two_ct", 128'(exp_q.size()), 128'(0));
        offer_block(rand128(), 1'b0, 100, 1'b0, 60, ok);
        chk("t3_stalled", 128'(ok), 128'(0));
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("t3_ctr_err", 128'(ctr_err), 128'(1));
        chk("t3_issues", 128'(issued_q.size()), 128'(2));
        check_issued("t3", v, 2);
        pulse_reset();
        check_idle("t3_rst");
`else
        send_msg("t3", v, 4, 80, -1);
        check_issued("t3", v, 4);
        chk("t3_ctr_err", 128'(ctr_err), 128'(0));
`endif

        v = rand128();
        send_msg("t4a", v, 1, 100, -1);
        v = rand128();
        send_msg("t4b", v, 3, 100, -1);
        check_issued("t4b", v, 1);

        v = rand128();
        send_msg("t6", v, 6, 100, 2);
        check_issued("t6", v, 6);

        do_start(rand128());
        reached = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (pipe_q.size() >= 5) begin
                reached = 1;
                break;
            end
        end
        chk("t5_inflight", 128'(reached), 128'(1));
        pulse_reset();
        check_idle("t5_rst");
        sink_pct = 100;
        v = rand128();
        send_msg("t5_restart", v, 5, 100, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
